multififo_wn_rn: RTL and testbench

//  Multi-lane FIFO. Each cycle it accepts 0..NW words and delivers 0..NR words. All counts
//  are parametrised, and an optional partial-accept mode is provided. Sits between wide

---
 rtl/multififo_pkg.sv | 35 +++
 rtl/multififo_lane_mux.sv | 29 ++
 rtl/multififo_wn_rn.sv | 150 +++++++++++++++
 tb/tb_multififo_wn_rn.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multififo_pkg.sv
// Shared helpers for the multi-lane FIFO.
// Modulo pointer add, unsigned min and the per-cycle grant bundle.
package multififo_pkg;

    localparam int CNTW = 16;

    typedef struct packed {
        logic [CNTW-1:0] wtake;
        logic [CNTW-1:0] rtake;
        logic            wr_ovf;
        logic            rd_ovf;
    } grant_t;

    // Operands stay below 2*depth, so one conditional subtract wraps.
    function automatic logic [CNTW-1:0] ptr_add(
        input logic [CNTW-1:0] ptr,
        input logic [CNTW-1:0] inc,
        input logic [CNTW-1:0] depth
    );
        logic [CNTW-1:0] sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    function automatic logic [CNTW-1:0] umin(
        input logic [CNTW-1:0] a,
        input logic [CNTW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/multififo_lane_mux.sv
// Read-side lane selector: picks storage word (base + LANE) mod DEPTH.
// One instance per read lane.
module multififo_lane_mux
    import multififo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    parameter int LANE  = 0
) (
    input  logic [PW-1:0]          base_i,
    input  logic [DEPTH*WIDTH-1:0] mem_i,
    output logic [WIDTH-1:0]       word_o
);

    logic [CNTW-1:0] idx;

    assign idx = ptr_add(CNTW'(base_i), CNTW'(LANE), CNTW'(DEPTH));

    always_comb begin
        word_o = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (idx == CNTW'(e)) begin
                word_o = mem_i[e*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/multififo_wn_rn.sv
// Multi-lane FIFO: up to NW words in and NR words out per cycle.
// Grants use start-of-cycle occupancy only; no write-to-read bypass.
module multififo_wn_rn
    import multififo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NW      = 10,
    parameter int NR      = 1,
    parameter int PARTIAL = 0,
    localparam int WW     = $clog2(NW + 1),
    localparam int RW     = $clog2(NR + 1),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                softreset,
    input  logic [WW-1:0]       writes,
    input  logic [NW*WIDTH-1:0] din,
    input  logic [RW-1:0]       reads,
    output logic [WW-1:0]       wtaken,
    output logic [RW-1:0]       rtaken,
    output logic [NR-1:0]       rvalid,
    output logic [NR*WIDTH-1:0] dout,
    output logic [15:0]         count,
    output logic [15:0]         frees,
    output logic                err
);

    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic                   err_q, err_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [CNTW-1:0]        woff  [DEPTH];
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic [WIDTH-1:0]       rword [NR];
    logic [CNTW-1:0]        frees_w;
    grant_t                 g;

    assign frees_w = CNTW'(DEPTH) - count_q;

    always_comb begin
        g = '0;
        g.wr_ovf = CNTW'(writes) > CNTW'(NW);
        g.rd_ovf = CNTW'(reads) > CNTW'(NR);
        if (!softreset && !g.wr_ovf) begin
            if (PARTIAL != 0) begin
                g.wtake = umin(CNTW'(writes), frees_w);
            end else if (CNTW'(writes) <= frees_w) begin
                g.wtake = CNTW'(writes);
            end
        end
        if (!softreset && !g.rd_ovf) begin
            if (PARTIAL != 0) begin
                g.rtake = umin(CNTW'(reads), count_q);
            end else if (CNTW'(reads) <= count_q) begin
                g.rtake = CNTW'(reads);
            end
        end
    end

    always_comb begin
        wptr_d  = '0;
        rptr_d  = '0;
        count_d = '0;
        err_d   = 1'b0;
        if (!softreset) begin
            wptr_d  = PW'(ptr_add(CNTW'(wptr_q), g.wtake, CNTW'(DEPTH)));
            rptr_d  = PW'(ptr_add(CNTW'(rptr_q), g.rtake, CNTW'(DEPTH)));
            count_d = count_q + g.wtake - g.rtake;
            err_d   = err_q | g.wr_ovf | g.rd_ovf;
        end
    end

    // Each entry finds which write lane (if any) lands on it this cycle.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
            if (CNTW'(e) >= CNTW'(wptr_q)) begin
                woff[e] = CNTW'(e) - CNTW'(wptr_q);
            end else begin
                woff[e] = CNTW'(e) + CNTW'(DEPTH) - CNTW'(wptr_q);
            end
            for (int k = 0; k < NW; k++) begin
                if (woff[e] == CNTW'(k) && CNTW'(k) < g.wtake) begin
                    mem_d[e] = din[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_flat[e*WIDTH +: WIDTH] = mem_q[e];
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        multififo_lane_mux #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .PW    (PW),
            .LANE  (k)
        ) u_mux (
            .base_i (rptr_q),
            .mem_i  (mem_flat),
            .word_o (rword[k])
        );
    end

    always_comb begin
        rvalid = '0;
        dout   = '0;
        for (int k = 0; k < NR; k++) begin
            rvalid[k] = CNTW'(k) < g.rtake;
            if (rvalid[k]) begin
                dout[k*WIDTH +: WIDTH] = rword[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

    assign wtaken = WW'(g.wtake);
    assign rtaken = RW'(g.rtake);
    assign count  = count_q;
    assign frees  = frees_w;
    assign err    = err_q;

endmodule

// File: tb/tb_multififo_wn_rn.sv
// Directed bench for multififo_wn_rn: default, PARTIAL=1 and
// NR=4/DEPTH=6 instances driven side by side.
module tb_multififo_wn_rn;

    logic clk;
    logic rst_n;
    logic softreset;

    // default instance: DEPTH 8, NW 10, NR 1, PARTIAL 0
    logic [3:0]   d_writes;
    logic [319:0] d_din;
    logic [0:0]   d_reads;
    logic [3:0]   d_wtaken;
    logic [0:0]   d_rtaken;
    logic [0:0]   d_rvalid;
    logic [31:0]  d_dout;
    logic [15:0]  d_count;
    logic [15:0]  d_frees;
    logic         d_err;

    // PARTIAL=1 instance
    logic [3:0]   p_writes;
    logic [319:0] p_din;
    logic [0:0]   p_reads;
    logic [3:0]   p_wtaken;
    logic [0:0]   p_rtaken;
    logic [0:0]   p_rvalid;
    logic [31:0]  p_dout;
    logic [15:0]  p_count;
    logic [15:0]  p_frees;
    logic         p_err;

    // wide-read instance: DEPTH 6, NW 6, NR 4
    logic [2:0]   w_writes;
    logic [191:0] w_din;
    logic [2:0]   w_reads;
    logic [2:0]   w_wtaken;
    logic [2:0]   w_rtaken;
    logic [3:0]   w_rvalid;
    logic [127:0] w_dout;
    logic [15:0]  w_count;
    logic [15:0]  w_frees;
    logic         w_err;

    int tests;
    int fails;

    multififo_wn_rn u_dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset),
        .writes(d_writes), .din(d_din), .reads(d_reads),
        .wtaken(d_wtaken), .rtaken(d_rtaken), .rvalid(d_rvalid),
        .dout(d_dout), .count(d_count), .frees(d_frees), .err(d_err)
    );

    multififo_wn_rn #(.PARTIAL(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .softreset(softreset),
        .writes(p_writes), .din(p_din), .reads(p_reads),
        .wtaken(p_wtaken), .rtaken(p_rtaken), .rvalid(p_rvalid),
        .dout(p_dout), .count(p_count), .frees(p_frees), .err(p_err)
    );

    multififo_wn_rn #(.DEPTH(6), .NW(6), .NR(4)) u_w (
        .clk(clk), .rst_n(rst_n), .softreset(softreset),
        .writes(w_writes), .din(w_din), .reads(w_reads),
        .wtaken(w_wtaken), .rtaken(w_rtaken), .rvalid(w_rvalid),
        .dout(w_dout), .count(w_count), .frees(w_frees), .err(w_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_d", 128'(d_count <= 16'd8), 128'd1);
        chk("inv_p", 128'(p_count <= 16'd8), 128'd1);
        chk("inv_w", 128'(w_count <= 16'd6), 128'd1);
    endtask

    task automatic dlane(input int k, input logic [31:0] v);
        d_din[k*32 +: 32] = v;
    endtask

    task automatic plane(input int k, input logic [31:0] v);
        p_din[k*32 +: 32] = v;
    endtask

    task automatic wlane(input int k, input logic [31:0] v);
        w_din[k*32 +: 32] = v;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        softreset = 1'b0;
        d_writes = '0; d_din = '0; d_reads = '0;
        p_writes = '0; p_din = '0; p_reads = '0;
        w_writes = '0; w_din = '0; w_reads = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", d_count, 0);
        chk("rst_frees", d_frees, 8);
        chk("rst_err", d_err, 0);
        chk("rst_rvalid", d_rvalid, 0);
        chk("rst_dout", d_dout, 0);
        chk("rst_w_frees", w_frees, 6);
        rst_n = 1'b1;

        // A,B,C into default; 6 words into PARTIAL; 4 into empty wide FIFO
        d_writes = 4'd3;
        dlane(0, 32'hD000_0001); dlane(1, 32'hD000_0002);
        dlane(2, 32'hD000_0003);
        p_writes = 4'd6;
        for (int k = 0; k < 6; k++) plane(k, 32'hE000_0000 + k);
        w_writes = 3'd4;
        w_reads  = 3'd4;
        for (int k = 0; k < 4; k++) wlane(k, 32'h10 + k);
        #1;
        chk("t1_wtaken", d_wtaken, 3);
        chk("p_wtaken6", p_wtaken, 6);
        chk("w_wtaken4", w_wtaken, 4);
        chk("w_empty_rtaken", w_rtaken, 0);
        chk("w_empty_dout", w_dout, 0);
        tick();
        chk("t1_count3", d_count, 3);
        chk("p_count6", p_count, 6);
        chk("w_count4", w_count, 4);

        d_writes = 4'd0;
        d_reads  = 1'b1;
        p_writes = 4'd3;
        for (int k = 0; k < 3; k++) plane(k, 32'hF000_0000 + k);
        w_writes = 3'd0;
        w_reads  = 3'd4;
        #1;
        chk("t1_dout_A", d_dout, 32'hD000_0001);
        chk("t1_rtaken", d_rtaken, 1);
        chk("t1_rvalid", d_rvalid, 1);
        chk("t2_p_wtaken2", p_wtaken, 2);
        chk("w_rtaken4", w_rtaken, 4);
        chk("w_rvalid", w_rvalid, 4'hF);
        chk("w_dout0", w_dout,
            {32'h13, 32'h12, 32'h11, 32'h10});
        tick();
        chk("t1_count2", d_count, 2);
        chk("t2_p_count8", p_count, 8);
        chk("t2_p_frees0", p_frees, 0);
        chk("w_count0", w_count, 0);
        chk("t3_wptr4", u_w.wptr_q, 4);
        chk("t3_rptr4", u_w.rptr_q, 4);

        // D..G brings default to 6; wide FIFO gets 5 words across the wrap
        d_reads  = 1'b0;
        d_writes = 4'd4;
        dlane(0, 32'hD000_0004); dlane(1, 32'hD000_0005);
        dlane(2, 32'hD000_0006); dlane(3, 32'hD000_0007);
        p_writes = 4'd0;
        w_reads  = 3'd0;
        w_writes = 3'd5;
        for (int k = 0; k < 5; k++) wlane(k, 32'h20 + k);
        #1;
        chk("d_wtaken4", d_wtaken, 4);
        chk("t3_wtaken5", w_wtaken, 5);
        tick();
        chk("d_count6", d_count, 6);
        chk("t3_count5", w_count, 5);
        chk("t3_wptr3", u_w.wptr_q, 3);

        d_writes = 4'd3;
        dlane(0, 32'hBAD0_0000); dlane(1, 32'hBAD0_0001);
        dlane(2, 32'hBAD0_0002);
        w_writes = 3'd0;
        w_reads  = 3'd4;
        #1;
        chk("t2_d_wtaken0", d_wtaken, 0);
        chk("t3_rtaken4", w_rtaken, 4);
        chk("t3_dout_wrap", w_dout,
            {32'h23, 32'h22, 32'h21, 32'h20});
        tick();
        chk("t2_d_count6", d_count, 6);
        chk("t2_d_err0", d_err, 0);
        chk("t3_count1", w_count, 1);
        chk("t3_rptr2", u_w.rptr_q, 2);

        // H,I fills default; wide FIFO asks 2 of 1 stored
        d_writes = 4'd2;
        dlane(0, 32'hD000_0008); dlane(1, 32'hD000_0009);
        w_reads = 3'd2;
        #1;
        chk("d_wtaken2", d_wtaken, 2);
        chk("w_short_rtaken", w_rtaken, 0);
        chk("w_short_dout", w_dout, 0);
        tick();
        chk("t4_count8", d_count, 8);
        chk("t4_frees0", d_frees, 0);
        chk("w_count1", w_count, 1);

        // full with simultaneous write and read
        d_writes = 4'd1;
        dlane(0, 32'hD000_000A);
        d_reads = 1'b1;
        w_reads = 3'd1;
        #1;
        chk("t4_wtaken0", d_wtaken, 0);
        chk("t4_rtaken1", d_rtaken, 1);
        chk("t4_dout_B", d_dout, 32'hD000_0002);
        chk("w_last_dout", w_dout, {96'h0, 32'h24});
        tick();
        chk("t4_count7", d_count, 7);
        chk("w_count0b", w_count, 0);

        d_reads = 1'b0;
        w_reads = 3'd0;
        #1;
        chk("t4_retry_wtaken", d_wtaken, 1);
        tick();
        chk("t4_count8b", d_count, 8);

        // overflowed write request
        d_writes = 4'd11;
        #1;
        chk("t5_wtaken0", d_wtaken, 0);
        tick();
        chk("t5_err1", d_err, 1);
        chk("t5_count8", d_count, 8);
        d_writes = 4'd0;
        tick();
        chk("t5_err_sticky", d_err, 1);

        softreset = 1'b1;
        d_writes  = 4'd1;
        d_reads   = 1'b1;
        #1;
        chk("t5_sr_wtaken", d_wtaken, 0);
        chk("t5_sr_rtaken", d_rtaken, 0);
        chk("t5_sr_dout", d_dout, 0);
        tick();
        softreset = 1'b0;
        d_writes  = 4'd0;
        d_reads   = 1'b0;
        #1;
        chk("t5_err0", d_err, 0);
        chk("t5_count0", d_count, 0);
        chk("t5_frees8", d_frees, 8);
        chk("t5_p_count0", p_count, 0);

        // five words in, then async reset while a read is pending
        d_writes = 4'd5;
        for (int k = 0; k < 5; k++) dlane(k, 32'hC000_0000 + k);
        tick();
        chk("t6_count5", d_count, 5);
        d_writes = 4'd0;
        d_reads  = 1'b1;
        #1;
        chk("t6_dout_pre", d_dout, 32'hC000_0000);
        rst_n = 1'b0;
        #1;
        chk("t6_count0", d_count, 0);
        chk("t6_dout0", d_dout, 0);
        chk("t6_rvalid0", d_rvalid, 0);
        chk("t6_frees8", d_frees, 8);
        d_reads = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
